// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory/IO port arbiter: FSM encoding,
// the address bit that selects the I/O register space, and the lock-run cap.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } arb_state_t;

    localparam int IO_ADDR_BIT  = 7;
    localparam int MAX_LOCK_RUN = 4;
    localparam int LOCK_RUN_W   = 3;
    localparam int COUNT_W      = 4;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-input round-robin picker: a lone request always wins; on a tie the
// requester that was not served last wins. The pick is one-hot or zero.
module arb_rr2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] pick
);

    // Tie-break on 'last', otherwise pass the single request straight through
    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = {req1, req0};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory/IO port between the CPU data port (requester 0) and
// the loader/debug engine (requester 1). Each grant holds the bus for a fixed
// number of cycles, pulses done on the last one and captures read data.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = 32
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_datain,
    output logic              mem_we,
    input  logic [31:0]       mem_dataout
);

    localparam logic [COUNT_W-1:0]    CNT_LOAD = COUNT_W'(ACCESS_CYCLES - 1);
    localparam logic [LOCK_RUN_W-1:0] RUN_MAX  = LOCK_RUN_W'(MAX_LOCK_RUN);

    arb_state_t             state, state_next;
    logic [COUNT_W-1:0]     cnt, cnt_next;
    logic [LOCK_RUN_W-1:0]  run, run_next;
    logic                   last, last_next;
    logic [1:0]             pick;
    logic                   capture0, capture1;
    logic                   err_set;
    logic                   io_block1;

    arb_rr2 u_rr (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .pick (pick)
    );

    // Requester 1 must never write the I/O register space
    assign io_block1 = we1 && addr1[IO_ADDR_BIT];

    // Next-state, counters and bus/handshake outputs decoded from the current state
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        run_next   = run;
        last_next  = last;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        mem_addr   = '0;
        mem_datain = '0;
        mem_we     = 1'b0;
        capture0   = 1'b0;
        capture1   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (pick[0]) begin
                    state_next = ACC0;
                    cnt_next   = CNT_LOAD;
                    run_next   = LOCK_RUN_W'(1);
                end else if (pick[1]) begin
                    state_next = ACC1;
                    cnt_next   = CNT_LOAD;
                    run_next   = LOCK_RUN_W'(1);
                end
            end
            ACC0: begin
                gnt0       = 1'b1;
                mem_addr   = addr0;
                mem_datain = wdata0;
                mem_we     = we0;
                if (cnt == '0) begin
                    done0     = 1'b1;
                    capture0  = !we0;
                    last_next = 1'b0;
                    if (lock0 && req0 && (run < RUN_MAX)) begin
                        cnt_next = CNT_LOAD;
                        run_next = run + LOCK_RUN_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - COUNT_W'(1);
                end
            end
            ACC1: begin
                gnt1       = 1'b1;
                mem_addr   = addr1;
                mem_datain = wdata1;
                mem_we     = we1 && !io_block1;
                err_set    = io_block1;
                if (cnt == '0) begin
                    done1     = 1'b1;
                    capture1  = !we1;
                    last_next = 1'b1;
                    if (lock1 && req1 && (run < RUN_MAX)) begin
                        cnt_next = CNT_LOAD;
                        run_next = run + LOCK_RUN_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - COUNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, access down-counter, lock-run length and round-robin history
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
            run   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            run   <= run_next;
            last  <= last_next;
        end
    end

    // Read-data capture at completion and the sticky I/O-write violation flag
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            rdata0 <= '0;
            rdata1 <= '0;
            err1   <= 1'b0;
        end else begin
            if (capture0) begin
                rdata0 <= mem_dataout;
            end
            if (capture1) begin
                rdata1 <= mem_dataout;
            end
            err1 <= err1 || err_set;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected responses computed
// from a behavioural memory model; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    localparam int AC     = 3;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_mem_we;
    } item_t;

    logic              clock = 1'b0;
    logic              clrn  = 1'b0;
    logic              req   [2];
    logic              we    [2];
    logic              lock  [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [31:0]       wdata [2];
    logic              gnt0, gnt1, done0, done1, err1, mem_we;
    logic [31:0]       rdata0, rdata1, mem_datain, mem_dataout;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        gnt_v, done_v;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd  [2];
    logic        err_model;
    item_t       q0[$];
    item_t       q1[$];
    item_t       pend   [2];
    bit          pend_v [2];
    int          cyc    [2];
    bit          mon_en = 1'b0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .clrn        (clrn),
        .req0        (req[0]),
        .req1        (req[1]),
        .we0         (we[0]),
        .we1         (we[1]),
        .lock0       (lock[0]),
        .lock1       (lock[1]),
        .addr0       (addr[0]),
        .addr1       (addr[1]),
        .wdata0      (wdata[0]),
        .wdata1      (wdata[1]),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .err1        (err1),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    assign gnt_v       = {gnt1, gnt0};
    assign done_v      = {done1, done0};
    assign mem_dataout = mem[mem_addr[7:0]];

    // Behavioural data memory / I/O block: level write enable, sampled at the edge
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] = mem_datain;
    end

    function automatic logic [31:0] init_val(input int i);
        return {8'hA5, 8'(i), 8'(~i), 8'h3C};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access by requester r: predict the response, queue it, drive the request
    task automatic applyStimulus(input int r, input logic [7:0] a, input logic w,
                                 input logic [31:0] d, input logic lk, input logic keep);
        item_t it;
        bit    ok;
        it.addr       = a;
        it.we         = w;
        it.wdata      = d;
        it.exp_mem_we = w && !(r == 1 && a[7]);
        if (r == 1 && w && a[7]) err_model = 1'b1;
        if (it.exp_mem_we) ref_mem[a] = d;
        if (!w) exp_rd[r] = ref_mem[a];
        it.exp_rdata = exp_rd[r];
        it.exp_err   = err_model;
        if (r == 0) q0.push_back(it); else q1.push_back(it);
        req[r]   = 1'b1;
        we[r]    = w;
        addr[r]  = {24'b0, a};
        wdata[r] = d;
        lock[r]  = lk;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (done_v[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput($sformatf("done_timeout_r%0d", r), 32'd0, 32'd1);
        @(posedge clock);
        #1;
        if (!keep) begin
            req[r]  = 1'b0;
            lock[r] = 1'b0;
        end
    endtask

    task automatic monitor_req(input int r);
        item_t it;
        int    qs;
        if (pend_v[r]) begin
            checkOutput($sformatf("rdata%0d", r), (r == 0) ? rdata0 : rdata1, pend[r].exp_rdata);
            if (r == 1) checkOutput("err1", 32'(err1), 32'(pend[r].exp_err));
            pend_v[r] = 1'b0;
        end
        qs = (r == 0) ? q0.size() : q1.size();
        if (gnt_v[r]) begin
            if (qs == 0) begin
                checkOutput($sformatf("spurious_gnt%0d", r), 32'd1, 32'd0);
            end else begin
                it = (r == 0) ? q0[0] : q1[0];
                checkOutput($sformatf("mem_addr_r%0d", r), mem_addr, {24'b0, it.addr});
                checkOutput($sformatf("mem_we_r%0d", r), 32'(mem_we), 32'(it.exp_mem_we));
                if (it.we) checkOutput($sformatf("mem_datain_r%0d", r), mem_datain, it.wdata);
                cyc[r]++;
                if (done_v[r]) begin
                    checkOutput($sformatf("access_len_r%0d", r), 32'(cyc[r]), 32'(AC));
                    cyc[r]    = 0;
                    pend[r]   = it;
                    pend_v[r] = 1'b1;
                    if (r == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end else if (done_v[r]) begin
            checkOutput($sformatf("done_without_gnt%0d", r), 32'd1, 32'd0);
        end
    endtask

    // Monitor: compares every bus cycle and every completion against the queues
    always @(negedge clock) begin
        if (!mon_en || !clrn) begin
            cyc[0] = 0; cyc[1] = 0;
            pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                checkOutput("gnt_overlap", 32'(gnt0 && gnt1), 32'd0);
            end else begin
                checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
                checkOutput("idle_mem_addr", mem_addr, 32'd0);
            end
            for (int r = 0; r < 2; r++) monitor_req(r);
        end
    end

    task automatic random_traffic(input int r, input int n);
        logic [7:0] a;
        logic       w, lk;
        for (int k = 0; k < n; k++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a | 8'h80;
            if (r == 1) a = a | 8'h40;
            lk = (k < n - 1) && ($urandom_range(0, 3) == 0);
            applyStimulus(r, a, w, $urandom, lk, lk);
            if (!lk) begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit saw;
        int n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        for (int r = 0; r < 2; r++) begin
            req[r] = 0; we[r] = 0; lock[r] = 0; addr[r] = '0; wdata[r] = '0; exp_rd[r] = '0;
        end
        err_model = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        checkOutput("rst_gnt0", 32'(gnt0), 0);
        checkOutput("rst_gnt1", 32'(gnt1), 0);
        checkOutput("rst_done", 32'(done_v), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_datain", mem_datain, 0);
        checkOutput("rst_rdata0", rdata0, 0);
        checkOutput("rst_rdata1", rdata1, 0);
        checkOutput("rst_err1", 32'(err1), 0);
        clrn = 1'b1;
        mon_en = 1'b1;

        // Tie after reset: requester 0 first, one IDLE cycle, then requester 1
        $display("[TB] tie after reset");
        @(posedge clock); #1;
        fork
            begin
                applyStimulus(0, 8'h04, 1'b0, 32'h0, 1'b0, 1'b0);
                checkOutput("tie_idle_gap", 32'(gnt_v), 0);
                @(posedge clock); #1;
                checkOutput("tie_second_gnt1", 32'(gnt1), 1);
            end
            applyStimulus(1, 8'h44, 1'b0, 32'h0, 1'b0, 1'b0);
            begin
                @(posedge clock); #1;
                checkOutput("tie_first_gnt0", 32'(gnt_v), 32'd1);
            end
        join

        // Lock run: four back-to-back ACC1 accesses, IDLE, then ACC0
        $display("[TB] lock run");
        @(posedge clock); #1;
        fork
            for (int k = 0; k < 6; k++)
                applyStimulus(1, 8'(8'h50 + 4 * k), 1'(k % 2), 32'h1000 + k, k < 5, k < 5);
            begin
                @(posedge clock); #1;
                applyStimulus(0, 8'h08, 1'b0, 32'h0, 1'b0, 1'b0);
            end
            begin
                saw = 1'b0;
                for (int i = 0; i < 50 && !saw; i++) begin
                    @(negedge clock);
                    if (gnt1) saw = 1'b1;
                end
                checkOutput("lock_gnt1_seen", 32'(saw), 1);
                n = 1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clock);
                    if (!gnt1) break;
                    n++;
                end
                checkOutput("lock_run_cycles", 32'(n), 32'(4 * AC));
                checkOutput("lock_idle_gap", 32'(gnt0), 0);
                @(negedge clock);
                checkOutput("lock_then_gnt0", 32'(gnt0), 1);
            end
        join

        // I/O write protection for requester 1 only
        $display("[TB] io write protection");
        applyStimulus(1, 8'hC0, 1'b1, 32'h11112222, 1'b0, 1'b0);
        applyStimulus(1, 8'hC0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 8'h80, 1'b1, 32'h33334444, 1'b0, 1'b0);
        applyStimulus(0, 8'h80, 1'b0, 32'h0, 1'b0, 1'b0);

        // Randomized concurrent traffic
        $display("[TB] random traffic");
        fork
            random_traffic(0, 30);
            random_traffic(1, 30);
        join

        // Reset in the second cycle of an ACC0 write
        $display("[TB] reset mid-access");
        repeat (3) @(negedge clock);
        mon_en = 1'b0;
        @(posedge clock); #1;
        ref_mem[8'h10] = 32'hCAFE0010;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hCAFE0010; lock[0] = 1'b0;
        @(posedge clock); #1;
        checkOutput("abort_gnt0_before", 32'(gnt0), 1);
        @(posedge clock); #2;
        clrn = 1'b0;
        #1;
        checkOutput("abort_gnt0", 32'(gnt0), 0);
        checkOutput("abort_mem_we", 32'(mem_we), 0);
        checkOutput("abort_done0", 32'(done0), 0);
        checkOutput("abort_rdata0", rdata0, 0);
        checkOutput("abort_err1", 32'(err1), 0);
        req[0] = 1'b0; we[0] = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0; err_model = 1'b0;
        repeat (2) @(negedge clock);
        clrn = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done0) saw = 1'b1;
        end
        checkOutput("abort_no_done0", 32'(saw), 0);

        @(posedge clock); #1;
        fork
            applyStimulus(0, 8'h10, 1'b0, 32'h0, 1'b0, 1'b0);
            applyStimulus(1, 8'h48, 1'b0, 32'h0, 1'b0, 1'b0);
            begin
                @(posedge clock); #1;
                checkOutput("tie_after_abort_gnt0", 32'(gnt_v), 32'd1);
            end
        join

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
